// File: rtl/eight_way_mux_arbiter_pkg.sv
// mux_arb_pkg: shared state encoding and widths for the eight-way mux arbiter
package mux_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;
  localparam int NUM_REQ = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/eight_way_mux_arbiter_pick.sv
// rr_priority_pick: combinational round-robin pick; i_req/i_last in, o_winner/o_found out, scan starts at i_last+1 and ends at i_last
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_last,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_found
);
  logic [SEL_W-1:0] w_idx;
  always_comb begin
    o_winner = i_last;
    o_found = 1'b0;
    w_idx = i_last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = i_last + SEL_W'(i);
      if (!o_found && i_req[w_idx]) begin
        o_winner = w_idx;
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eight_way_mux_arbiter.sv
// eight_way_mux_arbiter: round-robin owner of the 8:1 mux; i_clk/i_reset/i_req in, o_grant/o_selector_bits/o_grant_valid/o_owner_cycles registered out
module eight_way_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SEL_W-1:0]   o_selector_bits,
  output logic               o_grant_valid,
  output logic [7:0]         o_owner_cycles
);
  arb_state_t         r_state;
  logic [SEL_W-1:0]   r_last;
  logic [SEL_W-1:0]   w_winner;
  logic               w_found;
  logic               w_release;
  rr_priority_pick u_pick (
    .i_req(i_req),
    .i_last(r_last),
    .o_winner(w_winner),
    .o_found(w_found)
  );
  assign w_release = !i_req[o_selector_bits] || o_owner_cycles == 8'(MAX_HOLD);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ARB_IDLE;
      r_last <= 3'd7;
      o_grant <= '0;
      o_selector_bits <= '0;
      o_grant_valid <= 1'b0;
      o_owner_cycles <= '0;
    end else if (r_state == ARB_GRANT) begin
      if (w_release) begin
        r_state <= ARB_TURN;
        r_last <= o_selector_bits;
        o_grant <= '0;
        o_grant_valid <= 1'b0;
        o_owner_cycles <= '0;
      end else begin
        o_owner_cycles <= o_owner_cycles + 8'd1;
      end
    end else if (w_found) begin
      r_state <= ARB_GRANT;
      o_grant <= NUM_REQ'(1) << w_winner;
      o_selector_bits <= w_winner;
      o_grant_valid <= 1'b1;
      o_owner_cycles <= 8'd1;
    end else begin
      r_state <= ARB_IDLE;
    end
  end
endmodule

// File: tb/tb_eight_way_mux_arbiter.sv
// tb_eight_way_mux_arbiter: directed scoreboard bench for eight_way_mux_arbiter
module tb_eight_way_mux_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] grant, grant1, cnt, cnt1;
  logic [2:0] sel, sel1;
  logic       valid, valid1;
  logic [19:0] q[$];
  int checks = 0;
  int failures = 0;
  int n = 0;
  always #5 clk = ~clk;
  eight_way_mux_arbiter #(.MAX_HOLD(4)) u_dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_req(req),
    .o_grant(grant),
    .o_selector_bits(sel),
    .o_grant_valid(valid),
    .o_owner_cycles(cnt)
  );
  eight_way_mux_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .i_clk(clk),
    .i_reset(rst),
    .i_req(req),
    .o_grant(grant1),
    .o_selector_bits(sel1),
    .o_grant_valid(valid1),
    .o_owner_cycles(cnt1)
  );
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s, input logic v, input logic [7:0] c);
    logic [19:0] e;
    q.push_back({g, s, v, c});
    req = r;
    @(posedge clk);
    #1;
    e = q.pop_front();
    n++;
    chk($sformatf("step%0d", n), {grant, sel, valid, cnt}, e);
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(tag, {grant, sel, valid, cnt}, 20'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #1;
    chk("reset_init", {grant, sel, valid, cnt}, 20'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
    for (int c = 1; c <= 4; c++) step(8'h01, 8'h01, 3'd0, 1'b1, 8'(c));
    step(8'h01, 8'h00, 3'd0, 1'b0, 8'd0);
    step(8'h01, 8'h01, 3'd0, 1'b1, 8'd1);
    do_reset("reset_async_grant0");
    for (int k = 0; k <= 8; k++) begin
      for (int c = 1; c <= 4; c++) step(8'hFF, 8'h01 << (k % 8), 3'(k % 8), 1'b1, 8'(c));
      step(8'hFF, 8'h00, 3'(k % 8), 1'b0, 8'd0);
    end
    do_reset("reset_before_wrap");
    step(8'h40, 8'h40, 3'd6, 1'b1, 8'd1);
    step(8'h81, 8'h00, 3'd6, 1'b0, 8'd0);
    for (int c = 1; c <= 4; c++) step(8'h81, 8'h80, 3'd7, 1'b1, 8'(c));
    step(8'h81, 8'h00, 3'd7, 1'b0, 8'd0);
    step(8'h81, 8'h01, 3'd0, 1'b1, 8'd1);
    do_reset("reset_before_drop");
    step(8'h08, 8'h08, 3'd3, 1'b1, 8'd1);
    step(8'h28, 8'h08, 3'd3, 1'b1, 8'd2);
    step(8'h20, 8'h00, 3'd3, 1'b0, 8'd0);
    step(8'h20, 8'h20, 3'd5, 1'b1, 8'd1);
    step(8'h00, 8'h00, 3'd5, 1'b0, 8'd0);
    step(8'h00, 8'h00, 3'd5, 1'b0, 8'd0);
    do_reset("reset_before_owner4");
    step(8'h10, 8'h10, 3'd4, 1'b1, 8'd1);
    step(8'h10, 8'h10, 3'd4, 1'b1, 8'd2);
    req = 8'h11;
    do_reset("reset_mid_grant4");
    step(8'h11, 8'h01, 3'd0, 1'b1, 8'd1);
    do_reset("reset_before_hold1");
    req = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold1_%0d", i), {grant1, sel1, valid1, cnt1},
          (i % 2) ? {8'h00, 3'((i / 2) % 2), 1'b0, 8'd0} : {8'h01 << ((i / 2) % 2), 3'((i / 2) % 2), 1'b1, 8'd1});
    end
    if (q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eight_way_mux_arbiter.md
# eight_way_mux_arbiter

Round-robin arbiter that shares the single `output_line` of the 8:1 selector mux among eight requesters. It drives the mux's `selector_bits` and a one-hot grant back to the requesters. Each grant is bounded to `MAX_HOLD` cycles, and every handover passes through one dead turnaround cycle so downstream logic never samples the mux mid-switch. It sits directly in front of `EightToOneMux` in the datapath.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one requester may own the mux. Legal range is 1..255.
- `clk`  in  1: single clock. Everything is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  8: request vector. Bit i means requester i wants `output_line`.
- `grant`  out  8: one-hot grant, registered. All zero when nobody owns the mux.
- `selector_bits`  out  3: index fed to the mux's `selector_bits`, registered.
- `grant_valid`  out  1: high exactly when `grant` is non-zero and `output_line` is valid for the owner.
- `owner_cycles`  out  8: cycles the current owner has held the mux, counting 1..`MAX_HOLD`. Zero when idle or in turnaround.

## Operation
- State machine has three states: `ARB_IDLE`, `ARB_GRANT`, `ARB_TURN`.
- Internal `last` pointer is 3 bits and holds the index of the most recent owner.
- Winner rule: scan `req` starting at `last+1` and wrap modulo 8. If only `req[last]` is set, `last` itself wins.
- **IDLE**
  - If `req==0`: stay in IDLE.
  - Else: move to GRANT. Set `grant=onehot(winner)`, `selector_bits=winner`, `grant_valid=1`, `owner_cycles=1`.
- **GRANT**, with owner `o = selector_bits`:
  - If `req[o]==0` or `owner_cycles==MAX_HOLD`: move to TURN. Set `grant=0`, `grant_valid=0`, `owner_cycles=0`, `last=o`. `selector_bits` holds `o`.
  - Else: increment `owner_cycles`. Nothing else changes.
- **TURN**
  - If `req!=0`: move to GRANT with the winner chosen from `last+1`, same updates as IDLE→GRANT.
  - Else: move to IDLE. `selector_bits` keeps its value.
- Requests from non-owners never pre-empt the owner. They wait for a drop or expiry.
- `selector_bits` changes only on a TURN→GRANT or IDLE→GRANT edge. It never changes while `grant_valid=1`.
- With `MAX_HOLD=1`, every grant lasts exactly one cycle, followed by one TURN cycle.

## Timing
- Reset values, applied immediately on `reset` assertion without waiting for a clock edge: state=IDLE, `last=7` (so requester 0 has first priority), `grant=0`, `selector_bits=0`, `grant_valid=0`, `owner_cycles=0`.
- `req` is sampled at the rising edge. All outputs are registered, with no combinational path from `req` to any output.
- Latency from IDLE: `req` set before edge k gives a visible grant after edge k, so one cycle.
- A continuously requesting owner holds for exactly `MAX_HOLD` cycles, then spends 1 TURN cycle.
- Worst-case wait for a continuously asserted requester is 7·(`MAX_HOLD`+1) cycles.
- Owner drop: if `req[o]` falls before edge k, `grant_valid` is low after edge k. The grant spans the cycle in which the drop occurred.
- If the owner drops at the same edge its count reaches `MAX_HOLD`, there is a single TURN transition with no double handling.
- If `reset` is asserted mid-grant, all outputs clear asynchronously. After deassertion, arbitration restarts from priority 0.
- `owner_cycles` is 8 bits wide and never exceeds `MAX_HOLD`, so it cannot wrap.

## Structure
- Package `mux_arb_pkg` contains:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t`
  - `localparam NUM_REQ = 8`
  - `localparam SEL_W = 3`
- Sub-module `rr_priority_pick` is purely combinational.
  - Inputs: `req[7:0]`, `last[2:0]`.
  - Outputs: `winner[2:0]`, `found`.
  - Reused at both IDLE and TURN decision points.
- The top module holds the state register, the `last` pointer, the hold counter and the output registers.

## Test plan
- Reset then `req=8'h00` for 10 cycles: all outputs stay 0 and state stays IDLE. Assert `reset` asynchronously mid-cycle: outputs clear before the next edge.
- `req=8'h01`, `MAX_HOLD=4`, held continuously:
  - After the first edge: `grant=8'h01`, `sel=0`, `owner_cycles` steps 1,2,3,4.
  - Then 1 TURN cycle with `grant=0`, `sel=0`.
  - Then a re-grant to 0.
- `req=8'hFF` continuously, `MAX_HOLD=4`: owners rotate 0,1,2,…,7,0. Each owner gets 4 valid cycles separated by single TURN cycles. `selector_bits` is never changed while `grant_valid=1`.
- Wrap-around: with `last=6` (owner 6 just released) and `req=8'h81`, next grant goes to 7. After 7 releases, the next grant goes to 0.
- Early drop: owner 3 lowers `req[3]` at `owner_cycles=2` while `req[5]=1`. One edge later `grant_valid=0`, and the edge after that gives `grant=8'h20`, `sel=5`.
- Mid-grant reset while owner 4 holds: everything clears. After reset is released with `req=8'h11`, requester 0 wins first, not 4.
